// File: rtl/mem_interface.sv
// Word-addressed synchronous RAM behind a multi-cycle IDLE/WAIT/DONE handshake (MAR/MDR side).
// Define MEM_RANGE_CHK_EN to suppress out-of-range accesses and flag them on memErr.
module mem_interface #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] MARaddr,
  input  logic [DATA_W-1:0] mdrData,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mDataIn,
  output logic              memDone,
  output logic              busy,
  output logic              memErr
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t            state_q;
  req_t              req_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q, busy_q, err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0] idx_d;
  logic          in_rng_d;
  logic          fire_d;

  assign idx_d  = IW'(32'(req_q.addr) % 32'(DEPTH));
  assign fire_d = (state_q == WAIT) && (cnt_q == 4'd0);
`ifdef MEM_RANGE_CHK_EN
  assign in_rng_d = 32'(req_q.addr) < 32'(DEPTH);
`else
  assign in_rng_d = 1'b1;
`endif

  // RAM is never cleared; clr only blocks a commit on the abort edge.
  always_ff @(posedge clk) begin
    if (!clr && fire_d && in_rng_d && req_q.wr)
      mem[idx_d] <= req_q.data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (Read | Write) begin
            // Write wins when both are requested.
            req_q   <= '{wr: Write, addr: MARaddr, data: mdrData};
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!req_q.wr && in_rng_d) rdata_q <= mem[idx_d];
            done_q  <= 1'b1;
            err_q   <= !in_rng_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mDataIn = rdata_q;
  assign memDone = done_q;
  assign busy    = busy_q;
  assign memErr  = err_q;
endmodule
